// File: rtl/sevenseg_scan.sv
// N-digit multiplexed seven-segment driver: hex decode, leading-zero blanking,
// per-digit decimal points, PWM brightness and frame-synchronous input capture.
module sevenseg_scan #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned DIV_BITS = 16,
  parameter int unsigned BRIGHT_W = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  input  logic                  hex_en,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_start
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [DIV_BITS-1:0]  pre_q, pre_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 load_pending_q, load_pending_d;
  logic [4*DIGITS-1:0]  digits_s_q, digits_s_d;
  logic [DIGITS-1:0]    dp_s_q, dp_s_d;
  logic                 blank_s_q, blank_s_d;
  logic                 hex_s_q, hex_s_d;
  logic [BRIGHT_W-1:0]  bright_s_q, bright_s_d;
  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;
  logic [DIGITS-1:0]    an_q, an_d;
  logic                 frame_start_q, frame_start_d;

  logic                 tick_c, last_c, capture_c, pwm_on_c;
  logic [3:0]           cur_dig_c;
  logic                 cur_dp_c, cur_lz_c, all_zero_c;

  function automatic logic [6:0] decode7(input logic [3:0] v, input logic hex);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    if (!hex && (v > 4'd9)) s = 7'h7F;
    return s;
  endfunction

  // Scan timing and snapshot capture
  always_comb begin
    tick_c         = (pre_q == '1);
    last_c         = (idx_q == IDX_W'(DIGITS - 1));
    capture_c      = (tick_c && last_c) || load_pending_q;
    pre_d          = pre_q + DIV_BITS'(1);
    idx_d          = idx_q;
    if (tick_c) idx_d = last_c ? '0 : idx_q + IDX_W'(1);
    load_pending_d = 1'b0;
    frame_start_d  = capture_c;
    digits_s_d     = digits_s_q;
    dp_s_d         = dp_s_q;
    blank_s_d      = blank_s_q;
    hex_s_d        = hex_s_q;
    bright_s_d     = bright_s_q;
    if (capture_c) begin
      digits_s_d = digits_in;
      dp_s_d     = dp_in;
      blank_s_d  = blank_lz;
      hex_s_d    = hex_en;
      bright_s_d = brightness;
    end
  end

  // Current digit select; leading-zero run is accumulated from the top digit down
  always_comb begin
    cur_dig_c  = '0;
    cur_dp_c   = 1'b0;
    cur_lz_c   = 1'b0;
    all_zero_c = 1'b1;
    for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
      all_zero_c = all_zero_c & (digits_s_q[4*k +: 4] == 4'd0);
      if (idx_q == IDX_W'(k)) begin
        cur_dig_c = digits_s_q[4*k +: 4];
        cur_dp_c  = dp_s_q[k];
        cur_lz_c  = all_zero_c && (k != 0);
      end
    end
  end

  // Output pattern for the next edge, dark outside the PWM on-window
  always_comb begin
    pwm_on_c = (pre_q[DIV_BITS-1 -: BRIGHT_W] <= bright_s_q);
    seg_d    = 7'h7F;
    dp_d     = 1'b1;
    an_d     = '1;
    if (pwm_on_c) begin
      an_d  = ~(DIGITS'(1) << idx_q);
      seg_d = (blank_s_q && cur_lz_c) ? 7'h7F : decode7(cur_dig_c, hex_s_q);
      dp_d  = ~cur_dp_c;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pre_q          <= '0;
      idx_q          <= '0;
      load_pending_q <= 1'b1;
      digits_s_q     <= '0;
      dp_s_q         <= '0;
      blank_s_q      <= 1'b0;
      hex_s_q        <= 1'b0;
      bright_s_q     <= '0;
      seg_q          <= 7'h7F;
      dp_q           <= 1'b1;
      an_q           <= '1;
      frame_start_q  <= 1'b0;
    end else begin
      pre_q          <= pre_d;
      idx_q          <= idx_d;
      load_pending_q <= load_pending_d;
      digits_s_q     <= digits_s_d;
      dp_s_q         <= dp_s_d;
      blank_s_q      <= blank_s_d;
      hex_s_q        <= hex_s_d;
      bright_s_q     <= bright_s_d;
      seg_q          <= seg_d;
      dp_q           <= dp_d;
      an_q           <= an_d;
      frame_start_q  <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign an          = an_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Bench for sevenseg_scan (DIGITS=4, DIV_BITS=4, BRIGHT_W=2): cycle model plus
// directed scenarios with literal expectations.
module tb_sevenseg_scan;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic        clock, reset;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        blank_lz, hex_en;
  logic [1:0]  brightness;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_start;

  int tests = 0;
  int fails = 0;

  // Model state: clocks since reset release and the current snapshot
  int          c = 0;
  logic [15:0] s_digits = '0;
  logic [3:0]  s_dp = '0;
  logic        s_blank = 1'b0, s_hex = 1'b0;
  logic [1:0]  s_bright = '0;

  sevenseg_scan #(.DIGITS(4), .DIV_BITS(4), .BRIGHT_W(2)) dut (
    .clock(clock), .reset(reset), .digits_in(digits_in), .dp_in(dp_in),
    .blank_lz(blank_lz), .hex_en(hex_en), .brightness(brightness),
    .seg(seg), .dp(dp), .an(an), .frame_start(frame_start));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: predict outputs from the model, advance it, then compare the DUT
  task automatic step();
    logic [6:0] e_seg;
    logic       e_dp, e_fs, cap, lz;
    logic [3:0] e_an, dv;
    int         pre_v, slot;
    @(posedge clock);
    e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_fs = 1'b0;
    if (reset) begin
      c = 0; s_digits = '0; s_dp = '0; s_blank = 1'b0; s_hex = 1'b0; s_bright = '0;
    end else begin
      pre_v = c % 16;
      slot  = (c / 16) % 4;
      cap   = (c == 0) || (c % 64 == 63);
      e_fs  = cap;
      if ((pre_v / 4) <= int'(s_bright)) begin
        e_an[slot] = 1'b0;
        dv = s_digits[slot*4 +: 4];
        lz = s_blank && (slot > 0) && ((s_digits >> (4*slot)) == 16'd0);
        e_seg = (lz || (dv > 4'd9 && !s_hex)) ? 7'h7F : SEG_TAB[dv];
        e_dp  = ~s_dp[slot];
      end
      if (cap) begin
        s_digits = digits_in; s_dp = dp_in; s_blank = blank_lz;
        s_hex = hex_en; s_bright = brightness;
      end
      c++;
    end
    #1;
    chk("model_seg", 32'(seg), 32'(e_seg));
    chk("model_dp", 32'(dp), 32'(e_dp));
    chk("model_an", 32'(an), 32'(e_an));
    chk("model_frame_start", 32'(frame_start), 32'(e_fs));
  endtask

  task automatic wait_frame();
    logic seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step();
      if (frame_start) seen = 1'b1;
    end
    chk("wait_frame", 32'(seen), 32'd1);
  endtask

  task automatic wait_an(input logic [3:0] target);
    int n = 0;
    while (an !== target && n < 100) begin
      step();
      n++;
    end
    chk("wait_an", 32'(an), 32'(target));
  endtask

  task automatic check_frame(input string name, input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3);
    logic [6:0] exp [4];
    exp = '{s0, s1, s2, s3};
    wait_frame();
    step();
    for (int k = 0; k < 4; k++) begin
      wait_an(~(4'b0001 << k));
      chk($sformatf("%s_d%0d", name, k), 32'(seg), 32'(exp[k]));
    end
  endtask

  task automatic bright_run(input int exp_on, input string name);
    int cnt [4] = '{default: 0};
    wait_frame();
    for (int i = 0; i < 64; i++) begin
      step();
      for (int k = 0; k < 4; k++) if (an[k] == 1'b0) cnt[k]++;
      if (i == exp_on - 1) chk({name, "_last_on"}, 32'(an), 32'hE);
      if (i == exp_on) chk({name, "_first_off"}, 32'(an), 32'hF);
    end
    for (int k = 0; k < 4; k++) chk($sformatf("%s_cnt%0d", name, k), 32'(cnt[k]), 32'(exp_on));
  endtask

  initial begin
    reset = 1'b1; digits_in = 16'h1234; dp_in = 4'b0100;
    blank_lz = 1'b0; hex_en = 1'b0; brightness = 2'd3;
    repeat (3) step();
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'd1);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_fs", 32'(frame_start), 32'd0);

    reset = 1'b0;
    step();
    chk("rel_fs_hi", 32'(frame_start), 32'd1);
    step();
    chk("rel_fs_lo", 32'(frame_start), 32'd0);
    chk("scan_an0", 32'(an), 32'hE);
    chk("scan_seg0", 32'(seg), 32'(7'b0011001));
    chk("scan_dp0", 32'(dp), 32'd1);
    wait_an(4'hD);
    chk("scan_seg1", 32'(seg), 32'(7'b0110000));
    wait_an(4'hB);
    chk("scan_seg2", 32'(seg), 32'(7'b0100100));
    chk("scan_dp2", 32'(dp), 32'd0);
    wait_an(4'h7);
    chk("scan_seg3", 32'(seg), 32'(7'b1111001));
    chk("scan_dp3", 32'(dp), 32'd1);

    dp_in = 4'b0000; blank_lz = 1'b1;
    digits_in = 16'h0050;
    check_frame("lz_0050", 7'b1000000, 7'b0010010, 7'h7F, 7'h7F);
    digits_in = 16'h0000;
    check_frame("lz_0000", 7'b1000000, 7'h7F, 7'h7F, 7'h7F);
    digits_in = 16'h0500;
    check_frame("lz_0500", 7'b1000000, 7'b1000000, 7'b0010010, 7'h7F);

    blank_lz = 1'b0; hex_en = 1'b1; digits_in = 16'hABCD;
    check_frame("hex_on", 7'b0100001, 7'b1000110, 7'b0000011, 7'b0001000);
    hex_en = 1'b0;
    check_frame("hex_off", 7'h7F, 7'h7F, 7'h7F, 7'h7F);

    hex_en = 1'b1; brightness = 2'd0;
    bright_run(4, "br0");
    brightness = 2'd2;
    bright_run(12, "br2");

    brightness = 2'd3; digits_in = 16'h1111;
    check_frame("pre_1111", 7'b1111001, 7'b1111001, 7'b1111001, 7'b1111001);
    wait_frame();
    step();
    wait_an(4'hD);
    digits_in = 16'h2222;
    wait_an(4'hB);
    chk("mid_d2_old", 32'(seg), 32'(7'b1111001));
    wait_an(4'h7);
    chk("mid_d3_old", 32'(seg), 32'(7'b1111001));
    check_frame("post_2222", 7'b0100100, 7'b0100100, 7'b0100100, 7'b0100100);

    wait_frame();
    step();
    wait_an(4'hB);
    reset = 1'b1;
    step();
    chk("mrst_an", 32'(an), 32'hF);
    chk("mrst_seg", 32'(seg), 32'h7F);
    chk("mrst_dp", 32'(dp), 32'd1);
    reset = 1'b0;
    repeat (20) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan.md
Name: sevenseg_scan

Overview:
Parametrised N-digit multiplexed seven-segment driver. It is the successor to the fixed 4-digit display mux, adding:
- a configurable digit count and scan rate
- hex decode
- leading-zero blanking
- per-digit decimal points
- PWM brightness
- tear-free frame-synchronous input capture

It sits between the measurement/BCD logic and the board's active-low segment and anode pins.

Parameters:
DIGITS, 4, number of digits scanned (1..8).
DIV_BITS, 16, prescaler width; each digit slot lasts 2^DIV_BITS clocks.
BRIGHT_W, 3, brightness control width; requires BRIGHT_W <= DIV_BITS.

Ports:
clock  input  1  system clock; all logic on its rising edge.
reset  input  1  synchronous, active-high reset.
digits_in  input  4*DIGITS  digit values; digit k = digits_in[4k+3:4k], digit 0 rightmost.
dp_in  input  DIGITS  decimal point request per digit, 1 = lit.
blank_lz  input  1  1 = blank leading zeros.
hex_en  input  1  1 = decode 10..15 as A b C d E F; 0 = show those values blank.
brightness  input  BRIGHT_W  PWM duty; all-ones = full on.
seg  output  7  {g,f,e,d,c,b,a}, active-low.
dp  output  1  decimal point, active-low.
an  output  DIGITS  anode enables, active-low, one-hot-low.
frame_start  output  1  one-cycle pulse when a new frame (new snapshot) begins.

Behaviour:
- Reset (synchronous, active-high):
  - pre = 0, idx = 0, all shadow registers = 0, load_pending = 1.
  - Outputs: seg = 7'h7F, dp = 1, an = all ones, frame_start = 0.
  - Reset asserted mid-frame forces these values on the next edge.
- Prescaler pre (DIV_BITS wide) increments every clock and wraps freely. tick = (pre == all ones).
- Digit index idx:
  - advances on tick;
  - wraps DIGITS-1 -> 0;
  - non-power-of-2 DIGITS must wrap correctly (e.g. DIGITS=3: 0,1,2,0).
- Snapshot capture:
  - Shadow registers hold digits_in, dp_in, blank_lz, hex_en and brightness.
  - Capture happens on (tick && idx == DIGITS-1) or load_pending.
  - load_pending clears on the first cycle after reset is released.
  - frame_start is registered and is high for exactly the cycle after each capture.
  - Inputs changing mid-frame have no visible effect until the next capture.
- Outputs are registered: the values at edge n+1 are a function of pre, idx and the shadow contents at cycle n.
- Anode:
  - an[idx] = 0 only when pwm_on; all other anode bits = 1.
  - pwm_on = (pre[DIV_BITS-1 -: BRIGHT_W] <= brightness_s).
  - On-time is therefore (brightness_s+1) / 2^BRIGHT_W of each slot.
  - When pwm_on = 0: an = all ones, seg = 7'h7F, dp = 1.
- Decode (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - Values 10..15 with hex_en_s = 0 decode to 1111111.
- Leading-zero blanking:
  - When blank_lz_s = 1, digit k (k >= 1) is blanked (seg = 1111111) if digits DIGITS-1 down to k are all 0.
  - Digit 0 is never blanked.
  - A blanked digit still drives its anode and shows dp per dp_s[k].
- dp output = ~dp_s[idx], gated by pwm_on.
- No handshake. The block free-runs and never stalls.

Test Plan:
All scenarios use DIGITS=4, DIV_BITS=4, BRIGHT_W=2.

1. Reset and release:
   - Assert reset 3 cycles -> seg = 7F, dp = 1, an = 1111, frame_start = 0.
   - Release -> frame_start high for exactly 1 cycle.
   - Snapshot equals the inputs present at release.
2. Scan order and decode:
   - digits_in = 16'h1234, brightness = 3, dp_in = 4'b0100.
   - an cycles 1110 -> 1101 -> 1011 -> 0111, 16 clocks each.
   - seg = 0011001, 0110000, 0100100, 1111001 respectively.
   - dp = 0 only during an = 1011.
3. Leading-zero blanking, blank_lz = 1:
   - 16'h0050 -> digits 3 and 2 seg = 7F, digit 1 = 0010010, digit 0 = 1000000.
   - 16'h0000 -> only digit 0 shows 1000000.
   - 16'h0500 -> digit 0 shows 1000000 (zero not leading).
4. Hex:
   - 16'hABCD with hex_en = 1 -> 0100001, 1000110, 0000011, 0001000 on digits 0..3.
   - Same value with hex_en = 0 -> all digits 7F, anodes still scanning.
5. Brightness:
   - brightness = 0 -> each an bit low for exactly 4 of its 16 slot clocks, during pre = 0..3.
   - brightness = 2 -> low for 12 clocks.
6. Frame sync and mid-frame reset:
   - Change digits_in from 16'h1111 to 16'h2222 while idx = 1 -> digits 1..3 still show 1.
   - Digits show 2 only after the next frame_start.
   - Assert reset while idx = 2 -> an = 1111 and seg = 7F on the next edge.
